collision_scanner: RTL and testbench

- Parametrised successor to the single-frame, two-column bird/pipe collision check.
- Once per game frame it snapshots the bird height and NUM_PIPES pipe positions, then scans one pipe per gameClk cycle.
- Flags floor, ceiling and pipe collisions, and reports a sticky game-over hit with the index of the offending pipe.
- Counts pipes the bird has cleared, giving the score to the display/FSM layer.

---
 rtl/collision_scanner_if.sv | 30 +++
 rtl/collision_scanner.sv | 144 ++++++++++++++
 tb/tb_collision_scanner.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/collision_scanner_if.sv
// Bundles the frame-scan request (snapshot inputs, start/clear) and the scan results
// of collision_scanner. The game FSM uses the master side; the scanner uses the slave side.
interface collision_scanner_if #(
    parameter int NUM_PIPES = 4,
    parameter int COORD_W   = 11,
    parameter int SCORE_W   = 8
);
    localparam int IDX_W = $clog2(NUM_PIPES + 1);

    logic                          start;
    logic                          clear;
    logic [COORD_W-1:0]            bird_y;
    logic [NUM_PIPES*COORD_W-1:0]  pipe_x;
    logic [NUM_PIPES*COORD_W-1:0]  pipe_y;
    logic                          busy;
    logic                          done;
    logic                          hit;
    logic [IDX_W-1:0]              hit_index;
    logic [SCORE_W-1:0]            score;

    modport master (
        output start, clear, bird_y, pipe_x, pipe_y,
        input  busy, done, hit, hit_index, score
    );

    modport slave (
        input  start, clear, bird_y, pipe_x, pipe_y,
        output busy, done, hit, hit_index, score
    );
endinterface

// File: rtl/collision_scanner.sv
// Per-frame bird/pipe collision scanner: snapshots the bird and all pipes on start,
// then checks one pipe per gameClk cycle, keeping a sticky hit flag and a pass score.
module collision_scanner #(
    parameter int NUM_PIPES   = 4,
    parameter int COORD_W     = 11,
    parameter int SCORE_W     = 8,
    parameter int PIPE_HALF_W = 40,
    parameter int GAP_HALF    = 60,
    parameter int BIRD_X      = 160,
    parameter int BIRD_HALF   = 10,
    parameter int FLOOR_Y     = 10,
    parameter int CEIL_Y      = 470
) (
    input  logic                 gameClk,
    input  logic                 reset_n,
    collision_scanner_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_PIPES + 1);
    localparam int CNT_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam int SUM_W = COORD_W + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIPES - 1);
    localparam logic [IDX_W-1:0] FC_INDEX = IDX_W'(NUM_PIPES);

    // Constant sides of the compares, pre-summed at the wider width so nothing wraps.
    localparam logic [SUM_W-1:0] K_OV_HI  = SUM_W'(BIRD_X + BIRD_HALF + PIPE_HALF_W);
    localparam logic [SUM_W-1:0] K_BX     = SUM_W'(BIRD_X);
    localparam logic [SUM_W-1:0] K_PW_BH  = SUM_W'(PIPE_HALF_W + BIRD_HALF);
    localparam logic [SUM_W-1:0] K_BH     = SUM_W'(BIRD_HALF);
    localparam logic [SUM_W-1:0] K_GH     = SUM_W'(GAP_HALF);
    localparam logic [SUM_W-1:0] K_FLOOR  = SUM_W'(FLOOR_Y + BIRD_HALF);
    localparam logic [SUM_W-1:0] K_CEIL   = SUM_W'(CEIL_Y);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    logic [1:0]           state;
    logic [CNT_W-1:0]     idx;
    logic [COORD_W-1:0]   bird_y_p0;
    logic [COORD_W-1:0]   pipe_x_p0 [NUM_PIPES];
    logic [COORD_W-1:0]   pipe_y_p0 [NUM_PIPES];
    logic [NUM_PIPES-1:0] passed;
    logic                 hit_r;
    logic [IDX_W-1:0]     hit_index_r;
    logic [SCORE_W-1:0]   score_r;

    logic [SUM_W-1:0]     y_s;
    logic [SUM_W-1:0]     px_s;
    logic [SUM_W-1:0]     py_s;
    logic                 overlap;
    logic                 vmiss;
    logic                 pipe_hit;
    logic                 fc_hit;
    logic                 cleared;
    logic                 first_cycle;

    always_comb begin
        y_s         = SUM_W'(bird_y_p0);
        px_s        = SUM_W'(pipe_x_p0[idx]);
        py_s        = SUM_W'(pipe_y_p0[idx]);
        overlap     = (K_OV_HI > px_s) && (K_BX < px_s + K_PW_BH);
        vmiss       = (y_s + K_BH > py_s + K_GH) || (y_s + K_GH < py_s + K_BH);
        pipe_hit    = overlap && vmiss;
        fc_hit      = (y_s <= K_FLOOR) || (y_s + K_BH >= K_CEIL);
        cleared     = (px_s + K_PW_BH < K_BX);
        first_cycle = (idx == '0);
    end

    always_ff @(posedge gameClk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            bird_y_p0   <= '0;
            passed      <= '0;
            hit_r       <= 1'b0;
            hit_index_r <= '0;
            score_r     <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                pipe_x_p0[i] <= '0;
                pipe_y_p0[i] <= '0;
            end
        end else if (bus.clear) begin
            state       <= S_IDLE;
            idx         <= '0;
            passed      <= '0;
            hit_r       <= 1'b0;
            hit_index_r <= '0;
            score_r     <= '0;
        end else begin
            case (state)
                // Stage 0: frame snapshot; inputs are free to move during the scan
                S_IDLE: begin
                    if (bus.start) begin
                        bird_y_p0 <= bus.bird_y;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            pipe_x_p0[i] <= bus.pipe_x[i*COORD_W +: COORD_W];
                            pipe_y_p0[i] <= bus.pipe_y[i*COORD_W +: COORD_W];
                        end
                        idx   <= '0;
                        state <= S_SCAN;
                    end
                end
                // Scan stage: one pipe per cycle, floor/ceiling folded into the first
                S_SCAN: begin
                    if (!hit_r) begin
                        if (first_cycle && fc_hit) begin
                            hit_r       <= 1'b1;
                            hit_index_r <= FC_INDEX;
                        end else if (pipe_hit) begin
                            hit_r       <= 1'b1;
                            hit_index_r <= IDX_W'(idx);
                        end
                    end
                    if (cleared) begin
                        if (!passed[idx]) begin
                            score_r <= sat_inc(score_r);
                        end
                        passed[idx] <= 1'b1;
                    end else begin
                        passed[idx] <= 1'b0;
                    end
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.hit       = hit_r;
    assign bus.hit_index = hit_index_r;
    assign bus.score     = score_r;
endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner: a vector table of whole frames plus
// hand-written sequences for start-while-busy, clear mid-scan and async reset.
module tb_collision_scanner;
    logic gameClk = 1'b0;
    logic reset_n;

    always #5 gameClk = ~gameClk;

    collision_scanner_if #(.NUM_PIPES(4), .COORD_W(11), .SCORE_W(8)) bus ();
    collision_scanner_if #(.NUM_PIPES(4), .COORD_W(11), .SCORE_W(2)) bus2 ();

    assign bus2.start  = bus.start;
    assign bus2.clear  = bus.clear;
    assign bus2.bird_y = bus.bird_y;
    assign bus2.pipe_x = bus.pipe_x;
    assign bus2.pipe_y = bus.pipe_y;

    collision_scanner #(.NUM_PIPES(4), .COORD_W(11), .SCORE_W(8)) dut (
        .gameClk (gameClk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    collision_scanner #(.NUM_PIPES(4), .COORD_W(11), .SCORE_W(2)) dut2 (
        .gameClk (gameClk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    typedef struct {
        logic        do_clear;
        logic [10:0] by;
        logic [43:0] px;
        logic        ehit;
        logic [2:0]  eidx;
        logic [7:0]  escore;
    } vec_t;

    vec_t vt [21];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [43:0] mk(input int p0, input int p1, input int p2, input int p3);
        return {11'(p3), 11'(p2), 11'(p1), 11'(p0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge gameClk);
        #1;
    endtask

    task automatic set_vec(input int n, input logic c, input int by, input logic [43:0] px,
                           input logic eh, input int ei, input int es);
        vt[n].do_clear = c;
        vt[n].by       = 11'(by);
        vt[n].px       = px;
        vt[n].ehit     = eh;
        vt[n].eidx     = 3'(ei);
        vt[n].escore   = 8'(es);
    endtask

    task automatic run_frame(output int lat);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 20) begin
            step();
            lat++;
        end
        chk("busy_in_done", 32'(bus.busy), 32'd1);
        step();
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    initial begin
        int lat;
        int ndone;
        int first_done;
        logic [31:0] e2;

        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.clear  = 1'b0;
        bus.bird_y = 11'd240;
        bus.pipe_x = mk(180, 600, 600, 600);
        bus.pipe_y = mk(240, 240, 240, 240);

        set_vec(0,  1'b1, 240, mk(180, 600, 600, 600), 1'b0, 0, 0);
        set_vec(1,  1'b0, 295, mk(180, 600, 600, 600), 1'b1, 0, 0);
        set_vec(2,  1'b1, 290, mk(180, 600, 600, 600), 1'b0, 0, 0);
        set_vec(3,  1'b1, 100, mk(600, 600, 180, 170), 1'b1, 2, 0);
        set_vec(4,  1'b0, 100, mk(600, 600, 600, 170), 1'b1, 2, 0);
        set_vec(5,  1'b1, 20,  mk(180, 600, 600, 600), 1'b1, 4, 0);
        set_vec(6,  1'b1, 460, mk(180, 600, 600, 600), 1'b1, 4, 0);
        set_vec(7,  1'b1, 240, mk(180, 100, 600, 600), 1'b0, 0, 1);
        set_vec(8,  1'b0, 240, mk(180, 100, 600, 600), 1'b0, 0, 1);
        set_vec(9,  1'b0, 240, mk(180, 100, 600, 600), 1'b0, 0, 1);
        set_vec(10, 1'b0, 240, mk(180, 600, 600, 600), 1'b0, 0, 1);
        set_vec(11, 1'b0, 240, mk(180, 100, 600, 600), 1'b0, 0, 2);
        set_vec(12, 1'b1, 240, mk(180, 100, 600, 600), 1'b0, 0, 1);
        set_vec(13, 1'b0, 240, mk(180, 600, 600, 600), 1'b0, 0, 1);
        set_vec(14, 1'b0, 240, mk(180, 100, 600, 600), 1'b0, 0, 2);
        set_vec(15, 1'b0, 240, mk(180, 600, 600, 600), 1'b0, 0, 2);
        set_vec(16, 1'b0, 240, mk(180, 100, 600, 600), 1'b0, 0, 3);
        set_vec(17, 1'b0, 240, mk(180, 600, 600, 600), 1'b0, 0, 3);
        set_vec(18, 1'b0, 240, mk(180, 100, 600, 600), 1'b0, 0, 4);
        set_vec(19, 1'b0, 240, mk(180, 600, 600, 600), 1'b0, 0, 4);
        set_vec(20, 1'b0, 240, mk(180, 100, 600, 600), 1'b0, 0, 5);

        step();
        step();
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_done",  32'(bus.done),      32'd0);
        chk("rst_hit",   32'(bus.hit),       32'd0);
        chk("rst_idx",   32'(bus.hit_index), 32'd0);
        chk("rst_score", 32'(bus.score),     32'd0);
        reset_n = 1'b1;
        step();

        for (int n = 0; n < 21; n++) begin
            if (vt[n].do_clear) begin
                pulse_clear();
                chk("clr_hit",   32'(bus.hit),   32'd0);
                chk("clr_score", 32'(bus.score), 32'd0);
            end
            bus.bird_y = vt[n].by;
            bus.pipe_x = vt[n].px;
            run_frame(lat);
            e2 = (vt[n].escore > 8'd3) ? 32'd3 : 32'(vt[n].escore);
            chk($sformatf("v%0d_latency", n), 32'(lat),            32'd5);
            chk($sformatf("v%0d_hit", n),     32'(bus.hit),        32'(vt[n].ehit));
            chk($sformatf("v%0d_index", n),   32'(bus.hit_index),  32'(vt[n].eidx));
            chk($sformatf("v%0d_score", n),   32'(bus.score),      32'(vt[n].escore));
            chk($sformatf("v%0d_score2", n),  32'(bus2.score),     e2);
        end

        // Second start during a scan must neither queue nor add a done pulse.
        bus.bird_y = 11'd240;
        bus.pipe_x = mk(600, 600, 600, 600);
        bus.start  = 1'b1;
        ndone      = 0;
        first_done = 0;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 1) bus.start = 1'b0;
            if (c == 2) bus.start = 1'b1;
            if (c == 3) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (first_done == 0) first_done = c;
            end
        end
        chk("busy_start_dones", 32'(ndone),      32'd1);
        chk("busy_start_cycle", 32'(first_done), 32'd5);
        chk("busy_start_score", 32'(bus.score),  32'd5);

        // Clear in the middle of a colliding scan.
        bus.bird_y = 11'd295;
        bus.pipe_x = mk(180, 600, 600, 600);
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        step();
        step();
        chk("pre_clear_hit", 32'(bus.hit), 32'd1);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("mid_clear_busy",   32'(bus.busy),   32'd0);
        chk("mid_clear_hit",    32'(bus.hit),    32'd0);
        chk("mid_clear_score",  32'(bus.score),  32'd0);
        chk("mid_clear_score2", 32'(bus2.score), 32'd0);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.done) ndone++;
            step();
        end
        chk("mid_clear_nodone", 32'(ndone), 32'd0);

        // Asynchronous reset part-way through a scan.
        bus.pipe_x = mk(180, 100, 600, 600);
        run_frame(lat);
        chk("pre_rst_hit",   32'(bus.hit),   32'd1);
        chk("pre_rst_score", 32'(bus.score), 32'd1);
        bus.pipe_x = mk(180, 600, 600, 600);
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        step();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_busy",  32'(bus.busy),      32'd0);
        chk("async_done",  32'(bus.done),      32'd0);
        chk("async_hit",   32'(bus.hit),       32'd0);
        chk("async_idx",   32'(bus.hit_index), 32'd0);
        chk("async_score", 32'(bus.score),     32'd0);
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
